// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: opcodes, op-class and immediate-format codes, skid FSM states.
package decode_stage_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    CLS_OP     = 4'd0,
    CLS_OP_IMM = 4'd1,
    CLS_LOAD   = 4'd2,
    CLS_STORE  = 4'd3,
    CLS_BRANCH = 4'd4,
    CLS_JAL    = 4'd5,
    CLS_JALR   = 4'd6,
    CLS_LUI    = 4'd7,
    CLS_AUIPC  = 4'd8,
    CLS_SYSTEM = 4'd9
  } op_class_t;

  // FMT_NONE marks an illegal word: no registers, zero immediate.
  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_R    = 3'd1,
    FMT_I    = 3'd2,
    FMT_S    = 3'd3,
    FMT_B    = 3'd4,
    FMT_U    = 3'd5,
    FMT_J    = 3'd6
  } fmt_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

  function automatic logic fmt_reads_rs1(input fmt_t fmt);
    return (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
  endfunction

  function automatic logic fmt_reads_rs2(input fmt_t fmt);
    return (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
  endfunction

  function automatic logic fmt_writes_rd(input fmt_t fmt);
    return (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J);
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: assembles the sign-extended immediate for each instruction format.
module imm_gen
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  fmt_t            fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32;
  logic        unused_opcode_bits;

  assign unused_opcode_bits = ^instr[6:0];

  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U: imm32 = {instr[31:12], 12'b0};
      FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // All 32-bit immediates are already sign-extended at bit 31, so widening keeps that sign.
  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Decode stage: 2-entry skid buffer between fetch and execute, decoding the main slot combinationally.
// Handshake: a transfer happens on a rising edge where valid & ready are both high; valid and payload
// stay stable until that edge, and if_ready depends only on registered state.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [PC_W-1:0] if_pc,
  input  logic [31:0]     if_instr,
  input  logic            flush,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [PC_W-1:0] id_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [4:0]      rd_addr,
  output logic            uses_rs1,
  output logic            uses_rs2,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] imm,
  output logic [3:0]      op_class,
  output logic            illegal,
  output logic [1:0]      dbg_state
);

  skid_state_t     state, state_nxt;
  logic [PC_W-1:0] main_pc, skid_pc;
  logic [31:0]     main_instr, skid_instr;
  logic            in_fire, out_fire;
  logic            load_main_in, load_main_skid, load_skid;

  assign if_ready  = (state != ST_FULL);
  assign id_valid  = (state != ST_EMPTY);
  assign in_fire   = if_valid & if_ready;
  assign out_fire  = id_valid & id_ready;
  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_EMPTY;
      main_pc    <= '0;
      main_instr <= '0;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else begin
      state <= state_nxt;
      if (load_main_in) begin
        main_pc    <= if_pc;
        main_instr <= if_instr;
      end else if (load_main_skid) begin
        main_pc    <= skid_pc;
        main_instr <= skid_instr;
      end
      if (load_skid) begin
        skid_pc    <= if_pc;
        skid_instr <= if_instr;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            state_nxt    = ST_ONE;
            load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            state_nxt = ST_FULL;
            load_skid = 1'b1;
          end else if (out_fire) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_nxt      = ST_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  fmt_t        fmt;
  op_class_t   cls;
  logic        ill;
  logic [XLEN-1:0] imm_raw;

  always_comb begin
    fmt = FMT_NONE;
    cls = CLS_SYSTEM;
    ill = 1'b0;
    case (main_instr[6:0])
      OPC_OP:     begin fmt = FMT_R; cls = CLS_OP;     end
      OPC_OP_IMM: begin fmt = FMT_I; cls = CLS_OP_IMM; end
      OPC_LOAD:   begin fmt = FMT_I; cls = CLS_LOAD;   end
      OPC_STORE:  begin fmt = FMT_S; cls = CLS_STORE;  end
      OPC_BRANCH: begin fmt = FMT_B; cls = CLS_BRANCH; end
      OPC_JAL:    begin fmt = FMT_J; cls = CLS_JAL;    end
      OPC_JALR:   begin fmt = FMT_I; cls = CLS_JALR;   end
      OPC_LUI:    begin fmt = FMT_U; cls = CLS_LUI;    end
      OPC_AUIPC:  begin fmt = FMT_U; cls = CLS_AUIPC;  end
      OPC_SYSTEM: begin fmt = FMT_I; cls = CLS_SYSTEM; end
      default:    ill = 1'b1;
    endcase
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (main_instr),
    .fmt   (fmt),
    .imm   (imm_raw)
  );

  // Every decoded field reads as zero when no entry is present.
  always_comb begin
    id_pc    = '0;
    rs1_addr = '0;
    rs2_addr = '0;
    rd_addr  = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    funct3   = '0;
    funct7   = '0;
    imm      = '0;
    op_class = '0;
    illegal  = 1'b0;
    if (id_valid) begin
      id_pc    = main_pc;
      uses_rs1 = fmt_reads_rs1(fmt);
      uses_rs2 = fmt_reads_rs2(fmt);
      rs1_addr = fmt_reads_rs1(fmt) ? main_instr[19:15] : 5'd0;
      rs2_addr = fmt_reads_rs2(fmt) ? main_instr[24:20] : 5'd0;
      rd_addr  = fmt_writes_rd(fmt) ? main_instr[11:7] : 5'd0;
      funct3   = main_instr[14:12];
      funct7   = (fmt == FMT_R) ? main_instr[31:25] : 7'd0;
      imm      = imm_raw;
      op_class = cls;
      illegal  = ill;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed cases plus random traffic, checked against a queue-based reference.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid, if_ready, flush, id_valid, id_ready;
  logic [31:0] if_pc, if_instr, id_pc, imm;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        uses_rs1, uses_rs2, illegal;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [3:0]  op_class;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
    .if_instr(if_instr), .flush(flush), .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr), .uses_rs1(uses_rs1),
    .uses_rs2(uses_rs2), .funct3(funct3), .funct7(funct7), .imm(imm), .op_class(op_class),
    .illegal(illegal), .dbg_state(dbg_state)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [3:0]  cls;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  localparam logic [6:0] OPCS [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                       7'h6f, 7'h67, 7'h37, 7'h17, 7'h73};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode written directly from the ISA field layout.
  function automatic exp_t ref_decode(input logic [31:0] pc, input logic [31:0] i);
    exp_t e;
    e     = '0;
    e.pc  = pc;
    e.f3  = i[14:12];
    case (i[6:0])
      7'h33: begin
        e.cls = 4'd0; e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
        e.u1 = 1'b1; e.u2 = 1'b1; e.f7 = i[31:25];
      end
      7'h13, 7'h03, 7'h67, 7'h73: begin
        e.cls = (i[6:0] == 7'h13) ? 4'd1 : (i[6:0] == 7'h03) ? 4'd2 :
                (i[6:0] == 7'h67) ? 4'd6 : 4'd9;
        e.rd = i[11:7]; e.rs1 = i[19:15]; e.u1 = 1'b1;
        e.imm = 32'($signed(i[31:20]));
      end
      7'h23: begin
        e.cls = 4'd3; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.u1 = 1'b1; e.u2 = 1'b1;
        e.imm = 32'($signed({i[31:25], i[11:7]}));
      end
      7'h63: begin
        e.cls = 4'd4; e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.u1 = 1'b1; e.u2 = 1'b1;
        e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      end
      7'h37, 7'h17: begin
        e.cls = (i[6:0] == 7'h37) ? 4'd7 : 4'd8;
        e.rd  = i[11:7];
        e.imm = i & 32'hFFFF_F000;
      end
      7'h6f: begin
        e.cls = 4'd5; e.rd = i[11:7];
        e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      end
      default: begin
        e.cls = 4'd9; e.ill = 1'b1;
      end
    endcase
    return e;
  endfunction

  function automatic exp_t dut_out();
    exp_t o;
    o = '{pc: id_pc, rs1: rs1_addr, rs2: rs2_addr, rd: rd_addr, u1: uses_rs1, u2: uses_rs2,
          f3: funct3, f7: funct7, imm: imm, cls: op_class, ill: illegal};
    return o;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom();
    if ($urandom_range(0, 4) != 0) r[6:0] = OPCS[$urandom_range(0, 9)];
    return r;
  endfunction

  // Monitor/scoreboard: compares every cycle, then advances the reference for the coming edge.
  always @(negedge clk) begin
    exp_t want;
    int   sz;
    if (reset) begin
      exp_q.delete();
      check("rst_id_valid", id_valid, 1'b0);
      check("rst_if_ready", if_ready, 1'b1);
      check("rst_outputs", dut_out(), '0);
    end else begin
      sz   = exp_q.size();
      want = (sz > 0) ? exp_q[0] : '0;
      check("if_ready", if_ready, sz < 2);
      check("id_valid", id_valid, sz > 0);
      check("decode", dut_out(), want);
      if (flush) begin
        exp_q.delete();
      end else begin
        if (id_ready && sz > 0) void'(exp_q.pop_front());
        if (if_valid && sz < 2) exp_q.push_back(ref_decode(if_pc, if_instr));
      end
    end
  end

  // Present one entry and hold it until accepted; returns just after the accepting edge.
  task automatic push_one(input logic [31:0] pc, input logic [31:0] instr);
    int waited;
    waited   = 0;
    if_valid = 1'b1;
    if_pc    = pc;
    if_instr = instr;
    @(negedge clk);
    while (!if_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    check("push_accept", if_ready, 1'b1);
    @(posedge clk);
    #1;
    if_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; if_valid = 1'b0; if_pc = '0; if_instr = '0; flush = 1'b0; id_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // addi x1,x0,5
    push_one(32'h10, 32'h0050_0093);
    @(negedge clk);
    check("t1_id_valid", id_valid, 1'b1);
    check("t1_rd", rd_addr, 5'd1);
    check("t1_rs1", rs1_addr, 5'd0);
    check("t1_uses_rs2", uses_rs2, 1'b0);
    check("t1_imm", imm, 32'h0000_0005);
    check("t1_class", op_class, CLS_OP_IMM);

    // beq x1,x2,-8
    @(posedge clk); #1;
    push_one(32'h14, 32'hFE20_8CE3);
    @(negedge clk);
    check("t2_rs1", rs1_addr, 5'd1);
    check("t2_rs2", rs2_addr, 5'd2);
    check("t2_rd", rd_addr, 5'd0);
    check("t2_imm", imm, 32'hFFFF_FFF8);
    check("t2_class", op_class, CLS_BRANCH);

    // lui x5,0x12345 then an all-zero word
    @(posedge clk); #1;
    push_one(32'h18, 32'h1234_52B7);
    @(negedge clk);
    check("t3_rd", rd_addr, 5'd5);
    check("t3_uses_rs1", uses_rs1, 1'b0);
    check("t3_imm", imm, 32'h1234_5000);
    @(posedge clk); #1;
    push_one(32'h1c, 32'h0000_0000);
    @(negedge clk);
    check("t3_illegal", illegal, 1'b1);
    check("t3_ill_class", op_class, CLS_SYSTEM);
    check("t3_ill_rd", rd_addr, 5'd0);
    @(posedge clk); #1;

    // Back-pressure: fill both slots, then release and stream the rest.
    id_ready = 1'b0;
    push_one(32'h0, rand_instr());
    push_one(32'h1, rand_instr());
    @(negedge clk);
    check("t4_full_if_ready", if_ready, 1'b0);
    check("t4_full_state", dbg_state, ST_FULL);
    @(posedge clk); #1;
    id_ready = 1'b1;
    push_one(32'h2, rand_instr());
    push_one(32'h3, rand_instr());
    repeat (4) @(posedge clk);
    #1;

    // Flush while full with a new entry offered.
    id_ready = 1'b0;
    push_one(32'h50, rand_instr());
    push_one(32'h51, rand_instr());
    flush = 1'b1; if_valid = 1'b1; if_pc = 32'h99; if_instr = 32'h0050_0093;
    @(posedge clk); #1;
    flush = 1'b0; if_valid = 1'b0;
    @(negedge clk);
    check("t5_id_valid", id_valid, 1'b0);
    check("t5_if_ready", if_ready, 1'b1);
    @(posedge clk); #1;
    // Flush with one entry held and an acceptable entry offered in the same cycle.
    push_one(32'h60, rand_instr());
    flush = 1'b1; if_valid = 1'b1; if_pc = 32'h98; if_instr = 32'h0050_0093;
    @(posedge clk); #1;
    flush = 1'b0; if_valid = 1'b0;
    @(negedge clk);
    check("t5b_id_valid", id_valid, 1'b0);
    id_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Asynchronous reset mid-cycle while full.
    id_ready = 1'b0;
    push_one(32'h70, rand_instr());
    push_one(32'h71, rand_instr());
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("t6_id_valid", id_valid, 1'b0);
    check("t6_if_ready", if_ready, 1'b1);
    check("t6_outputs", dut_out(), '0);
    @(posedge clk); #1;
    reset = 1'b0;
    id_ready = 1'b1;
    push_one(32'h40, 32'h0050_0093);
    @(negedge clk);
    check("t6_post_pc", id_pc, 32'h40);
    check("t6_post_rd", rd_addr, 5'd1);
    check("t6_post_imm", imm, 32'h5);
    @(posedge clk); #1;

    // Random traffic with back-pressure and occasional flush.
    repeat (600) begin
      if_valid = ($urandom_range(0, 2) != 0);
      if_pc    = $urandom();
      if_instr = rand_instr();
      id_ready = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 24) == 0);
      @(posedge clk);
      #1;
    end
    if_valid = 1'b0; flush = 1'b0; id_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
